// File: rtl/npu_core.sv
// npu_core: single-MAC fixed-point engine that evaluates one fully connected
// layer. The host loads a header plus weight/bias words through a config FIFO,
// streams Q16.16 operands through an input FIFO and drains Q16.16 results
// from an output FIFO.
//
// Ports:
//   CLK, RST                       clock; synchronous active-high reset
//   npu_input_data / _write_enable push one signed Q16.16 operand
//   npu_config_data / _write_enable push one 26-bit configuration word
//   npu_output_fifo_read_enable    pop the output FIFO head
//   npu_output_data                output FIFO head (0 when empty)
//   npu_output_fifo_empty          output FIFO holds no entries
//   npu_input_fifo_full            input FIFO holds FIFO_DEPTH entries
//   npu_config_fifo_full           config FIFO holds FIFO_DEPTH entries

// Synchronous FIFO with registered flags and a registered first-word-fall-
// through head. Push while full and pop while empty are ignored.
module npu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             do_push, do_pop;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    // The new head is the word being written this cycle when the read pointer
    // lands on the write slot; otherwise it is already in storage.
    if (empty_d)                             head_d = '0;
    else if (do_push && wr_ptr_q == rd_ptr_d) head_d = wdata;
    else                                     head_d = mem[rd_ptr_d];
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // NOTE: storage is never reset; the pointers and count define which entries
  // are valid, so resetting the array would only cost reset fan-out.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign head  = head_q;
  assign empty = empty_q;
  assign full  = full_q;
endmodule

module npu_core #(
  parameter int FIFO_DEPTH = 16,
  parameter int WMEM_DEPTH = 1024,
  parameter int XBUF_DEPTH = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] npu_input_data,
  input  logic        npu_input_fifo_write_enable,
  input  logic [25:0] npu_config_data,
  input  logic        npu_config_fifo_write_enable,
  input  logic        npu_output_fifo_read_enable,
  output logic [31:0] npu_output_data,
  output logic        npu_output_fifo_empty,
  output logic        npu_input_fifo_full,
  output logic        npu_config_fifo_full
);
  localparam int WA = $clog2(WMEM_DEPTH);
  localparam int XA = $clog2(XBUF_DEPTH);
  localparam int BW = 17;  // body index: up to 256 * 255 words

  typedef enum logic [2:0] {S_LOAD, S_GATHER, S_MAC, S_BIAS, S_PUSH} state_e;

  // Header bits above relu_en and body bits above the Q8.8 value carry no
  // meaning, so only [16:0] is queued.
  logic [8:0]  unused_cfg_bits;
  assign unused_cfg_bits = npu_config_data[25:17];

  logic [16:0] cfg_head;
  logic        cfg_empty, cfg_pop;
  logic [31:0] in_head;
  logic        in_empty, in_pop;
  logic        out_full, out_push;

  state_e          state_q, state_d;
  logic            hdr_seen_q, hdr_seen_d;
  logic [7:0]      n_q, n_d, m_q, m_d;
  logic            relu_q, relu_d;
  logic [BW-1:0]   body_idx_q, body_idx_d, waddr_q, waddr_d;
  logic [7:0]      gidx_q, gidx_d, n_idx_q, n_idx_d, m_idx_q, m_idx_d;
  logic [47:0]     acc_q, acc_d;
  logic [31:0]     res_q, res_d;

  logic [15:0]        wmem [WMEM_DEPTH];
  logic [31:0]        xbuf [XBUF_DEPTH];
  logic               wmem_we, xbuf_we;
  logic [15:0]        wmem_rdata;
  logic [31:0]        xbuf_rdata;
  logic [BW-1:0]      body_total;
  logic signed [47:0] w_ext, x_ext, prod;
  logic [47:0]        bias_ext, bias_sum;

  npu_fifo #(.WIDTH(17), .DEPTH(FIFO_DEPTH)) u_cfg_fifo (
    .CLK(CLK), .RST(RST),
    .push(npu_config_fifo_write_enable), .wdata(npu_config_data[16:0]),
    .pop(cfg_pop), .head(cfg_head), .empty(cfg_empty), .full(npu_config_fifo_full)
  );

  npu_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .CLK(CLK), .RST(RST),
    .push(npu_input_fifo_write_enable), .wdata(npu_input_data),
    .pop(in_pop), .head(in_head), .empty(in_empty), .full(npu_input_fifo_full)
  );

  npu_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .CLK(CLK), .RST(RST),
    .push(out_push), .wdata(res_q),
    .pop(npu_output_fifo_read_enable), .head(npu_output_data),
    .empty(npu_output_fifo_empty), .full(out_full)
  );

  // Datapath: weights past the end of WMEM were discarded at load, read as 0.
  assign wmem_rdata = (waddr_q < BW'(WMEM_DEPTH)) ? wmem[waddr_q[WA-1:0]] : '0;
  assign xbuf_rdata = xbuf[n_idx_q[XA-1:0]];
  assign w_ext      = {{32{wmem_rdata[15]}}, wmem_rdata};
  assign x_ext      = {{16{xbuf_rdata[31]}}, xbuf_rdata};
  assign prod       = w_ext * x_ext;  // Q8.8 * Q16.16 = Q24.24, wraps at 48 bits
  assign bias_ext   = {{16{wmem_rdata[15]}}, wmem_rdata, 16'h0000};
  assign bias_sum   = acc_q + bias_ext;
  assign body_total = BW'(m_q) * (BW'(n_q) + BW'(1));

  always_comb begin
    state_d    = state_q;
    hdr_seen_d = hdr_seen_q;
    n_d        = n_q;
    m_d        = m_q;
    relu_d     = relu_q;
    body_idx_d = body_idx_q;
    waddr_d    = waddr_q;
    gidx_d     = gidx_q;
    n_idx_d    = n_idx_q;
    m_idx_d    = m_idx_q;
    acc_d      = acc_q;
    res_d      = res_q;
    cfg_pop    = 1'b0;
    in_pop     = 1'b0;
    out_push   = 1'b0;
    wmem_we    = 1'b0;
    xbuf_we    = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (!cfg_empty) begin
          cfg_pop = 1'b1;
          if (!hdr_seen_q) begin
            hdr_seen_d = 1'b1;
            n_d        = (cfg_head[7:0] == 8'd0) ? 8'd1 : cfg_head[7:0];
            m_d        = (cfg_head[15:8] == 8'd0) ? 8'd1 : cfg_head[15:8];
            relu_d     = cfg_head[16];
            body_idx_d = '0;
          end else begin
            wmem_we = (body_idx_q < BW'(WMEM_DEPTH));
            if (body_idx_q == body_total - BW'(1)) begin
              state_d = S_GATHER;
              gidx_d  = '0;
            end else begin
              body_idx_d = body_idx_q + BW'(1);
            end
          end
        end
      end
      S_GATHER: begin
        // A new header may only cut in between vectors, never mid-gather.
        if (gidx_q == 8'd0 && !cfg_empty) begin
          state_d    = S_LOAD;
          hdr_seen_d = 1'b0;
        end else if (!in_empty) begin
          in_pop  = 1'b1;
          xbuf_we = 1'b1;
          if (gidx_q == n_q - 8'd1) begin
            state_d = S_MAC;
            gidx_d  = '0;
            n_idx_d = '0;
            m_idx_d = '0;
            waddr_d = '0;
            acc_d   = '0;
          end else begin
            gidx_d = gidx_q + 8'd1;
          end
        end
      end
      S_MAC: begin
        acc_d   = acc_q + prod;
        waddr_d = waddr_q + BW'(1);
        if (n_idx_q == n_q - 8'd1) state_d = S_BIAS;
        else                       n_idx_d = n_idx_q + 8'd1;
      end
      S_BIAS: begin
        acc_d   = bias_sum;
        res_d   = (relu_q && bias_sum[39]) ? '0 : bias_sum[39:8];
        waddr_d = waddr_q + BW'(1);
        state_d = S_PUSH;
      end
      S_PUSH: begin
        if (!out_full) begin
          out_push = 1'b1;
          if (m_idx_q == m_q - 8'd1) begin
            state_d = S_GATHER;
            gidx_d  = '0;
          end else begin
            state_d = S_MAC;
            m_idx_d = m_idx_q + 8'd1;
            n_idx_d = '0;
            acc_d   = '0;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_LOAD;
      hdr_seen_q <= 1'b0;
      n_q        <= '0;
      m_q        <= '0;
      relu_q     <= 1'b0;
      body_idx_q <= '0;
      waddr_q    <= '0;
      gidx_q     <= '0;
      n_idx_q    <= '0;
      m_idx_q    <= '0;
      acc_q      <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      hdr_seen_q <= hdr_seen_d;
      n_q        <= n_d;
      m_q        <= m_d;
      relu_q     <= relu_d;
      body_idx_q <= body_idx_d;
      waddr_q    <= waddr_d;
      gidx_q     <= gidx_d;
      n_idx_q    <= n_idx_d;
      m_idx_q    <= m_idx_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wmem_we) wmem[body_idx_q[WA-1:0]] <= cfg_head[15:0];
    if (xbuf_we) xbuf[gidx_q[XA-1:0]]     <= in_head;
  end
endmodule

// File: tb/tb_npu_core.sv
// Self-checking bench for npu_core: directed scenarios with randomized
// weights and operands, results compared against a plain-arithmetic model
// of one fully connected layer.
`timescale 1ns/1ps
module tb_npu_core;
  typedef shortint sq_t[$];
  typedef int      iq_t[$];

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] npu_input_data = '0;
  logic        npu_input_fifo_write_enable = 1'b0;
  logic [25:0] npu_config_data = '0;
  logic        npu_config_fifo_write_enable = 1'b0;
  logic        npu_output_fifo_read_enable = 1'b0;
  logic [31:0] npu_output_data;
  logic        npu_output_fifo_empty;
  logic        npu_input_fifo_full;
  logic        npu_config_fifo_full;

  int n_assert = 0;
  int n_fail   = 0;

  // Layer currently programmed, as the model sees it.
  int  lay_n, lay_m;
  bit  lay_relu;
  sq_t lay_body;

  npu_core #(.FIFO_DEPTH(16), .WMEM_DEPTH(1024), .XBUF_DEPTH(256)) dut (
    .CLK(CLK),
    .RST(RST),
    .npu_input_data(npu_input_data),
    .npu_input_fifo_write_enable(npu_input_fifo_write_enable),
    .npu_config_data(npu_config_data),
    .npu_config_fifo_write_enable(npu_config_fifo_write_enable),
    .npu_output_fifo_read_enable(npu_output_fifo_read_enable),
    .npu_output_data(npu_output_data),
    .npu_output_fifo_empty(npu_output_fifo_empty),
    .npu_input_fifo_full(npu_input_fifo_full),
    .npu_config_fifo_full(npu_config_fifo_full)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  // Q8.8 weight times Q16.16 operand summed exactly, bias scaled to Q24.24,
  // then the Q16.16 window of the 48-bit wrapped sum.
  function automatic logic [31:0] model_neuron(input int m, input iq_t xv);
    longint      acc = 0;
    logic [63:0] bits;
    logic [31:0] r;
    int          base = m * (lay_n + 1);
    for (int n = 0; n < lay_n; n++)
      acc += longint'(lay_body[base + n]) * longint'(xv[n]);
    acc += longint'(lay_body[base + lay_n]) * 64'sd65536;
    bits = acc;
    r = bits[39:8];
    if (lay_relu && r[31]) r = '0;
    return r;
  endfunction

  function automatic sq_t rand_body(input int cnt);
    sq_t q;
    for (int i = 0; i < cnt; i++) q.push_back(shortint'($urandom));
    return q;
  endfunction

  task automatic write_cfg(input logic [25:0] w);
    int guard = 0;
    while (npu_config_fifo_full && guard < 1000) begin
      step();
      guard++;
    end
    npu_config_data = w;
    npu_config_fifo_write_enable = 1'b1;
    step();
    npu_config_fifo_write_enable = 1'b0;
  endtask

  task automatic push_input(input logic [31:0] x);
    int guard = 0;
    while (npu_input_fifo_full && guard < 1000) begin
      step();
      guard++;
    end
    npu_input_data = x;
    npu_input_fifo_write_enable = 1'b1;
    step();
    npu_input_fifo_write_enable = 1'b0;
  endtask

  task automatic pop_output(output logic [31:0] d, output bit got);
    int guard = 0;
    got = 1'b0;
    d   = '0;
    while (npu_output_fifo_empty && guard < 2000) begin
      step();
      guard++;
    end
    if (!npu_output_fifo_empty) begin
      got = 1'b1;
      d   = npu_output_data;
      npu_output_fifo_read_enable = 1'b1;
      step();
      npu_output_fifo_read_enable = 1'b0;
    end
  endtask

  // Header upper bits and body upper bits carry random junk on purpose.
  task automatic load_layer(input int n_raw, input int m_raw, input bit relu, input sq_t body);
    lay_n    = (n_raw == 0) ? 1 : n_raw;
    lay_m    = (m_raw == 0) ? 1 : m_raw;
    lay_relu = relu;
    lay_body = body;
    write_cfg({9'($urandom), relu, 8'(m_raw), 8'(n_raw)});
    foreach (body[i]) write_cfg({10'($urandom), 16'(body[i])});
  endtask

  task automatic test_reset();
    apply_reset();
    n_assert++;
    if (npu_output_fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_out_empty: got %b want 1", npu_output_fifo_empty);
    end
    n_assert++;
    if (npu_input_fifo_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_full: got %b want 0", npu_input_fifo_full);
    end
    n_assert++;
    if (npu_config_fifo_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_cfg_full: got %b want 0", npu_config_fifo_full);
    end
    n_assert++;
    if (npu_output_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h want 00000000", npu_output_data);
    end
  endtask

  task automatic test_basic_mac();
    sq_t         b;
    int          cnt;
    logic [31:0] d;
    bit          got;
    apply_reset();
    b.push_back(16'sh0100);
    b.push_back(16'sh0200);
    b.push_back(16'sh0080);
    load_layer(2, 1, 1'b0, b);
    repeat (8) step();
    push_input(32'h0002_0000);
    push_input(32'h0003_0000);
    step();  // edge at which the second operand is popped
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (npu_output_fifo_empty && cnt < 50);
    // Pop cycle + 2 MAC + BIAS + PUSH = N+3 cycles, i.e. N+2 edges after the pop.
    n_assert++;
    if (cnt !== 4) begin
      n_fail++; $display("FAIL basic_latency: got %0d edges after pop want 4", cnt);
    end
    n_assert++;
    if (npu_output_data !== 32'h0008_8000) begin
      n_fail++; $display("FAIL basic_value: got %h want 00088000", npu_output_data);
    end
    pop_output(d, got);
    step();
    n_assert++;
    if (npu_output_fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL basic_drained: empty got %b want 1", npu_output_fifo_empty);
    end
  endtask

  task automatic test_relu();
    sq_t         b;
    logic [31:0] d, exp_d;
    bit          got;
    b.push_back(shortint'(16'hFF00));
    b.push_back(16'sh0000);
    for (int r = 1; r >= 0; r--) begin
      load_layer(1, 1, r[0], b);
      repeat (8) step();
      push_input(32'h0002_0000);
      pop_output(d, got);
      exp_d = (r == 1) ? 32'h0000_0000 : 32'hFFFE_0000;
      n_assert++;
      if (!got || d !== exp_d) begin
        n_fail++; $display("FAIL relu_%0d: got %h (valid %b) want %h", r, d, got, exp_d);
      end
    end
  endtask

  task automatic test_fifo_bounds();
    iq_t         xs;
    sq_t         b;
    logic [31:0] d;
    bit          got;
    apply_reset();
    for (int i = 0; i < 17; i++) xs.push_back(int'($urandom));
    for (int i = 0; i < 17; i++) begin
      npu_input_data = 32'(xs[i]);
      npu_input_fifo_write_enable = 1'b1;
      step();
      n_assert++;
      if (npu_input_fifo_full !== (i >= 15)) begin
        n_fail++; $display("FAIL in_full_after_%0d: got %b want %b", i + 1, npu_input_fifo_full, i >= 15);
      end
    end
    npu_input_fifo_write_enable = 1'b0;
    npu_output_fifo_read_enable = 1'b1;
    step();
    npu_output_fifo_read_enable = 1'b0;
    n_assert++;
    if (npu_output_fifo_empty !== 1'b1 || npu_output_data !== 32'h0) begin
      n_fail++; $display("FAIL empty_pop: empty %b data %h want 1 00000000", npu_output_fifo_empty, npu_output_data);
    end
    // N=0, M=0 behave as 1x1; weight 1.0 and bias 0 pass operands through.
    b.push_back(16'sh0100);
    b.push_back(16'sh0000);
    load_layer(0, 0, 1'b0, b);
    for (int i = 0; i < 16; i++) begin
      pop_output(d, got);
      n_assert++;
      if (!got || d !== 32'(xs[i])) begin
        n_fail++; $display("FAIL passthru_%0d: got %h (valid %b) want %h", i, d, got, 32'(xs[i]));
      end
    end
    repeat (20) step();
    n_assert++;
    if (npu_output_fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL dropped_17th: empty got %b want 1", npu_output_fifo_empty);
    end
  endtask

  task automatic test_backpressure();
    iq_t         xv;
    logic [31:0] exp_q[$];
    logic [31:0] d;
    bit          got;
    apply_reset();
    load_layer(1, 20, 1'b0, rand_body(40));
    xv.push_back(int'($urandom));
    for (int m = 0; m < 20; m++) exp_q.push_back(model_neuron(m, xv));
    repeat (5) step();
    push_input(32'(xv[0]));
    repeat (150) step();
    n_assert++;
    if (npu_output_fifo_empty !== 1'b0 || npu_output_data !== exp_q[0]) begin
      n_fail++; $display("FAIL bp_head: empty %b data %h want 0 %h", npu_output_fifo_empty, npu_output_data, exp_q[0]);
    end
    for (int i = 0; i < 20; i++) begin
      pop_output(d, got);
      n_assert++;
      if (!got || d !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_result_%0d: got %h (valid %b) want %h", i, d, got, exp_q[i]);
      end
      if (i == 0) repeat (30) step();
    end
    repeat (30) step();
    n_assert++;
    if (npu_output_fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL bp_extra: empty got %b want 1", npu_output_fifo_empty);
    end
  endtask

  task automatic test_stream();
    iq_t         xs;
    logic [31:0] exp_q[$];
    apply_reset();
    load_layer(11, 12, 1'b0, rand_body(144));
    xs.push_back(2);
    for (int i = 1; i < 33; i++) xs.push_back(3);
    for (int v = 0; v < 3; v++) begin
      iq_t xv;
      for (int n = 0; n < 11; n++) xv.push_back(xs[v * 11 + n]);
      for (int m = 0; m < 12; m++) exp_q.push_back(model_neuron(m, xv));
    end
    fork
      begin
        foreach (xs[i]) push_input(32'(xs[i]));
      end
      begin
        logic [31:0] d;
        bit          got;
        for (int i = 0; i < 36; i++) begin
          pop_output(d, got);
          n_assert++;
          if (!got || d !== exp_q[i]) begin
            n_fail++; $display("FAIL stream_%0d: got %h (valid %b) want %h", i, d, got, exp_q[i]);
          end
        end
      end
    join
    repeat (20) step();
    n_assert++;
    if (npu_output_fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL stream_extra: empty got %b want 1", npu_output_fifo_empty);
    end
  endtask

  task automatic test_reset_mid_mac();
    sq_t         b;
    logic [31:0] d, x;
    bit          got;
    apply_reset();
    load_layer(40, 3, 1'b0, rand_body(123));
    repeat (5) step();
    for (int i = 0; i < 43; i++) push_input($urandom);
    write_cfg(26'h3FF_FFFF);
    repeat (5) step();
    apply_reset();
    n_assert++;
    if (npu_output_fifo_empty !== 1'b1 || npu_input_fifo_full !== 1'b0 ||
        npu_config_fifo_full !== 1'b0 || npu_output_data !== 32'h0) begin
      n_fail++; $display("FAIL midrst_flags: empty %b in_full %b cfg_full %b data %h want 1 0 0 00000000",
                         npu_output_fifo_empty, npu_input_fifo_full, npu_config_fifo_full, npu_output_data);
    end
    b.push_back(16'sh0100);
    b.push_back(16'sh0000);
    load_layer(1, 1, 1'b0, b);
    repeat (5) step();
    x = $urandom;
    push_input(x);
    pop_output(d, got);
    n_assert++;
    if (!got || d !== x) begin
      n_fail++; $display("FAIL midrst_reconfig: got %h (valid %b) want %h", d, got, x);
    end
    repeat (20) step();
    n_assert++;
    if (npu_output_fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL midrst_stale: empty got %b want 1", npu_output_fifo_empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_relu();
    test_fifo_bounds();
    test_backpressure();
    test_stream();
    test_reset_mid_mac();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
